// File: rtl/stack_unit.sv
// Hardware stack engine: pushes/pops return PC and flag byte to data memory.
// Responds to the control unit's stack handshake and masters the data bus.
module stack_unit #(
  parameter logic [7:0] STACK_INIT  = 8'h00,
  parameter int         STACK_DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stack_op_ongoing,
  input  logic       push_or_pop,
  output logic       stack_op_end,
  input  logic [7:0] push_pc,
  input  logic [7:0] push_flags,
  output logic [7:0] return_addr,
  output logic [7:0] ret_flags,
  output logic [7:0] sp,
  output logic       bus_req,
  input  logic       bus_grant,
  output logic [7:0] mem_addr,
  output logic       mem_wr,
  output logic       mem_rd,
  output logic [7:0] mem_dout,
  input  logic [7:0] mem_din,
  output logic       stack_ovf,
  output logic       stack_unf,
  input  logic       dbg_is_brk,
  input  logic       dbg_sp_wr,
  input  logic [7:0] dbg_data_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER0,
    S_XFER1,
    S_END,
    S_WAITLOW
  } state_t;

  state_t state_q, state_d;

  logic       op_push_q;
  logic [7:0] pc_q;
  logic [7:0] flags_q;
  logic [7:0] sp_q;

  logic              in_idle;
  logic              dbg_wr;
  logic              accept;
  logic [7:0]        occ;
  logic signed [9:0] room;
  logic              push_err;
  logic              pop_err;
  logic              in_xfer;
  logic              active;
  logic [7:0]        xfer_addr;

  assign in_idle = (state_q == S_IDLE);
  assign dbg_wr  = in_idle && dbg_is_brk && dbg_sp_wr;
  // A debugger SP write takes the IDLE cycle; the request is seen next cycle
  assign accept  = in_idle && stack_op_ongoing && !dbg_wr;

  assign occ  = STACK_INIT - sp_q;
  assign room = $signed(10'(STACK_DEPTH)) - $signed({2'b00, occ});

  assign push_err = push_or_pop && (room < 10'sd2);
  assign pop_err  = !push_or_pop && (occ < 8'd2);

  assign in_xfer = (state_q == S_XFER0) || (state_q == S_XFER1);
  assign active  = in_xfer && bus_grant;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (push_err || pop_err) state_d = S_END;
          else                     state_d = S_REQ;
        end
      end
      S_REQ:     if (bus_grant) state_d = S_XFER0;
      S_XFER0:   if (bus_grant) state_d = S_XFER1;
      S_XFER1:   if (bus_grant) state_d = S_END;
      S_END:     state_d = S_WAITLOW;
      S_WAITLOW: if (!stack_op_ongoing) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    xfer_addr = 8'h00;
    unique case (1'b1)
      op_push_q && state_q == S_XFER0:  xfer_addr = sp_q - 8'd1;
      op_push_q && state_q == S_XFER1:  xfer_addr = sp_q - 8'd2;
      !op_push_q && state_q == S_XFER0: xfer_addr = sp_q;
      !op_push_q && state_q == S_XFER1: xfer_addr = sp_q + 8'd1;
      default:                          xfer_addr = 8'h00;
    endcase
  end

  always_comb begin
    bus_req      = (state_q == S_REQ) || in_xfer;
    stack_op_end = (state_q == S_END);
    mem_wr       = active && op_push_q;
    mem_rd       = active && !op_push_q;
    mem_addr     = active ? xfer_addr : 8'h00;
    mem_dout     = 8'h00;
    if (mem_wr) begin
      mem_dout = (state_q == S_XFER0) ? pc_q : flags_q;
    end
  end

  assign sp = sp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_push_q   <= 1'b0;
      pc_q        <= 8'h00;
      flags_q     <= 8'h00;
      sp_q        <= STACK_INIT;
      return_addr <= 8'h00;
      ret_flags   <= 8'h00;
      stack_ovf   <= 1'b0;
      stack_unf   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (dbg_wr) begin
        sp_q      <= dbg_data_in;
        stack_ovf <= 1'b0;
        stack_unf <= 1'b0;
      end
      if (accept) begin
        op_push_q <= push_or_pop;
        pc_q      <= push_pc;
        flags_q   <= push_flags;
        if (push_err) stack_ovf <= 1'b1;
        if (pop_err)  stack_unf <= 1'b1;
      end
      if (mem_rd && state_q == S_XFER0) ret_flags   <= mem_din;
      if (mem_rd && state_q == S_XFER1) return_addr <= mem_din;
      // SP moves only once both bytes are on the bus
      if (active && state_q == S_XFER1) begin
        sp_q <= op_push_q ? sp_q - 8'd2 : sp_q + 8'd2;
      end
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: stimulus queues expected bus
// transactions and end-pulse states; a negedge monitor pops and compares.
module tb_stack_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stack_op_ongoing;
  logic       push_or_pop;
  logic       stack_op_end;
  logic [7:0] push_pc;
  logic [7:0] push_flags;
  logic [7:0] return_addr;
  logic [7:0] ret_flags;
  logic [7:0] sp;
  logic       bus_req;
  logic       bus_grant;
  logic [7:0] mem_addr;
  logic       mem_wr;
  logic       mem_rd;
  logic [7:0] mem_dout;
  logic [7:0] mem_din;
  logic       stack_ovf;
  logic       stack_unf;
  logic       dbg_is_brk;
  logic       dbg_sp_wr;
  logic [7:0] dbg_data_in;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    logic [7:0] sp;
    logic [7:0] ra;
    logic [7:0] rf;
    logic       ovf;
    logic       unf;
  } end_t;

  txn_t exp_txn[$];
  end_t exp_end[$];

  logic [7:0] mem [256];

  stack_unit #(.STACK_INIT(8'h00), .STACK_DEPTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .stack_op_ongoing (stack_op_ongoing),
    .push_or_pop      (push_or_pop),
    .stack_op_end     (stack_op_end),
    .push_pc          (push_pc),
    .push_flags       (push_flags),
    .return_addr      (return_addr),
    .ret_flags        (ret_flags),
    .sp               (sp),
    .bus_req          (bus_req),
    .bus_grant        (bus_grant),
    .mem_addr         (mem_addr),
    .mem_wr           (mem_wr),
    .mem_rd           (mem_rd),
    .mem_dout         (mem_dout),
    .mem_din          (mem_din),
    .stack_ovf        (stack_ovf),
    .stack_unf        (stack_unf),
    .dbg_is_brk       (dbg_is_brk),
    .dbg_sp_wr        (dbg_sp_wr),
    .dbg_data_in      (dbg_data_in)
  );

  always #5 clk = ~clk;

  assign mem_din = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_dout;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every bus strobe and end pulse against the queues
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mem_wr || mem_rd) begin
        chk("strobe_granted", {31'd0, bus_grant}, 32'd1);
        checks++;
        if (exp_txn.size() == 0) begin
          failures++;
          $display("FAIL unexpected_txn: wr=%0b addr=%0h", mem_wr, mem_addr);
        end else begin
          txn_t t;
          t = exp_txn.pop_front();
          chk("txn_wr", {31'd0, mem_wr}, {31'd0, t.wr});
          chk("txn_addr", {24'd0, mem_addr}, {24'd0, t.addr});
          chk("txn_data", {24'd0, (mem_wr ? mem_dout : mem_din)},
              {24'd0, t.data});
        end
      end else begin
        chk("idle_addr", {24'd0, mem_addr}, 32'd0);
      end
      if (!mem_wr) chk("idle_dout", {24'd0, mem_dout}, 32'd0);
      if (stack_op_end) begin
        checks++;
        if (exp_end.size() == 0) begin
          failures++;
          $display("FAIL unexpected_end: sp=%0h", sp);
        end else begin
          end_t e;
          e = exp_end.pop_front();
          chk("end_sp", {24'd0, sp}, {24'd0, e.sp});
          chk("end_ret_addr", {24'd0, return_addr}, {24'd0, e.ra});
          chk("end_ret_flags", {24'd0, ret_flags}, {24'd0, e.rf});
          chk("end_ovf", {31'd0, stack_ovf}, {31'd0, e.ovf});
          chk("end_unf", {31'd0, stack_unf}, {31'd0, e.unf});
          chk("end_bus_req", {31'd0, bus_req}, 32'd0);
        end
      end
    end
  end

  task automatic exp_w(input logic wr, input logic [7:0] a,
                       input logic [7:0] d);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d;
    exp_txn.push_back(t);
  endtask

  task automatic exp_e(input logic [7:0] s, input logic [7:0] ra,
                       input logic [7:0] rf, input logic ovf,
                       input logic unf);
    end_t e;
    e.sp = s; e.ra = ra; e.rf = rf; e.ovf = ovf; e.unf = unf;
    exp_end.push_back(e);
  endtask

  // Called #1 after a posedge; grant bit n applies to cycle n+1
  task automatic do_op(input logic push, input logic [7:0] pc,
                       input logic [7:0] fl, input int exp_lat,
                       input logic [31:0] gmask, input int hold);
    int lat;
    push_or_pop      = push;
    push_pc          = pc;
    push_flags       = fl;
    stack_op_ongoing = 1'b1;
    @(posedge clk); #1;
    push_or_pop = ~push;
    push_pc     = 8'h00;
    push_flags  = 8'hFF;
    bus_grant   = gmask[0];
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (stack_op_end) lat = n;
      else if (exp_lat > 1) chk("bus_req_held", {31'd0, bus_req}, 32'd1);
      @(posedge clk); #1;
      bus_grant = (n < 32) ? gmask[n] : 1'b1;
    end
    chk("end_latency", lat, exp_lat);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    stack_op_ongoing = 1'b0;
    bus_grant        = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic dbg_write(input logic [7:0] v);
    dbg_is_brk  = 1'b1;
    dbg_sp_wr   = 1'b1;
    dbg_data_in = v;
    @(posedge clk); #1;
    dbg_is_brk = 1'b0;
    dbg_sp_wr  = 1'b0;
    chk("dbg_sp", {24'd0, sp}, {24'd0, v});
    chk("dbg_ovf_clr", {31'd0, stack_ovf}, 32'd0);
    chk("dbg_unf_clr", {31'd0, stack_unf}, 32'd0);
  endtask

  localparam logic [31:0] G_ALL   = 32'hFFFF_FFFF;
  localparam logic [31:0] G_STALL = 32'hFFFF_FF98;

  initial begin
    logic [7:0] s;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst              = 1'b1;
    stack_op_ongoing = 1'b0;
    push_or_pop      = 1'b0;
    push_pc          = 8'h00;
    push_flags       = 8'h00;
    bus_grant        = 1'b1;
    dbg_is_brk       = 1'b0;
    dbg_sp_wr        = 1'b0;
    dbg_data_in      = 8'h00;

    @(negedge clk);
    chk("rst_sp", {24'd0, sp}, 32'd0);
    chk("rst_ret_addr", {24'd0, return_addr}, 32'd0);
    chk("rst_ret_flags", {24'd0, ret_flags}, 32'd0);
    chk("rst_strobes", {29'd0, bus_req, mem_wr, mem_rd}, 32'd0);
    chk("rst_end", {31'd0, stack_op_end}, 32'd0);
    chk("rst_flags", {30'd0, stack_ovf, stack_unf}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    exp_w(1, 8'hFF, 8'h3A); exp_w(1, 8'hFE, 8'h05);
    exp_e(8'hFE, 8'h00, 8'h00, 0, 0);
    do_op(1, 8'h3A, 8'h05, 4, G_ALL, 0);

    exp_w(0, 8'hFE, 8'h05); exp_w(0, 8'hFF, 8'h3A);
    exp_e(8'h00, 8'h3A, 8'h05, 0, 0);
    do_op(0, 8'h00, 8'h00, 4, G_ALL, 0);

    exp_w(1, 8'hFF, 8'h3A); exp_w(1, 8'hFE, 8'h05);
    exp_e(8'hFE, 8'h3A, 8'h05, 0, 0);
    do_op(1, 8'h3A, 8'h05, 9, G_STALL, 0);
    chk("stall_mem_ff", {24'd0, mem[8'hFF]}, 32'h3A);
    chk("stall_mem_fe", {24'd0, mem[8'hFE]}, 32'h05);

    exp_w(0, 8'hFE, 8'h05); exp_w(0, 8'hFF, 8'h3A);
    exp_e(8'h00, 8'h3A, 8'h05, 0, 0);
    do_op(0, 8'h00, 8'h00, 4, G_ALL, 0);

    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      exp_w(1, s - 8'd1, 8'(i));
      exp_w(1, s - 8'd2, 8'(8'h10 + i));
      s = s - 8'd2;
      exp_e(s, 8'h3A, 8'h05, 0, 0);
      do_op(1, 8'(i), 8'(8'h10 + i), 4, G_ALL, 0);
    end
    exp_e(8'hE0, 8'h3A, 8'h05, 1, 0);
    do_op(1, 8'hEE, 8'hEE, 1, G_ALL, 0);
    chk("ovf_sticky", {31'd0, stack_ovf}, 32'd1);

    dbg_write(8'h00);
    exp_e(8'h00, 8'h3A, 8'h05, 0, 1);
    do_op(0, 8'h00, 8'h00, 1, G_ALL, 0);

    exp_w(1, 8'hFF, 8'h77); exp_w(1, 8'hFE, 8'h01);
    exp_e(8'hFE, 8'h3A, 8'h05, 0, 1);
    do_op(1, 8'h77, 8'h01, 4, G_ALL, 5);

    dbg_write(8'h80);
    dbg_write(8'h00);

    push_or_pop      = 1'b1;
    push_pc          = 8'h55;
    push_flags       = 8'h66;
    stack_op_ongoing = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst              = 1'b1;
    stack_op_ongoing = 1'b0;
    #1;
    chk("rstx_outs",
        {27'd0, bus_req, mem_wr, mem_rd, stack_op_end, stack_ovf}, 32'd0);
    chk("rstx_bus", {16'd0, mem_addr, mem_dout}, 32'd0);
    chk("rstx_sp", {24'd0, sp}, 32'd0);
    chk("rstx_ret", {16'd0, return_addr, ret_flags}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    exp_w(1, 8'hFF, 8'hAB); exp_w(1, 8'hFE, 8'hCD);
    exp_e(8'hFE, 8'h00, 8'h00, 0, 0);
    do_op(1, 8'hAB, 8'hCD, 4, G_ALL, 0);

    repeat (2) @(posedge clk);
    chk("txn_queue_drained", exp_txn.size(), 0);
    chk("end_queue_drained", exp_end.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware stack engine; the responder side of the control unit's stack handshake (stack_op_ongoing / push_or_pop / stack_op_end).
- On interrupt entry or subroutine call it pushes the return PC and the flag byte into data memory. On return it pops them back.
- Owns the stack pointer and masters the data-memory bus through the existing bus_req/bus_grant arbitration.

Parameters:
- STACK_INIT, 8'h00: SP value after reset or when the stack is empty; the stack grows downward, pre-decrement.
- STACK_DEPTH, 32: capacity in bytes. Must be even and ≤ 256.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- stack_op_ongoing  input  1  operation request, held high by the control unit until it sees stack_op_end.
- push_or_pop  input  1  1 = push, 0 = pop; sampled when the request is accepted.
- stack_op_end  output  1  one-cycle completion pulse.
- push_pc  input  8  return address to push; sampled at acceptance.
- push_flags  input  8  flag byte to push, {4'b0, ie, if, ...} packed by the caller; sampled at acceptance.
- return_addr  output  8  popped PC, registered.
- ret_flags  output  8  popped flag byte, registered.
- sp  output  8  current stack pointer.
- bus_req  output  1  data bus request.
- bus_grant  input  1  data bus grant.
- mem_addr  output  8  data memory address; 0 when not transferring (OR-bus).
- mem_wr  output  1  write strobe.
- mem_rd  output  1  read strobe.
- mem_dout  output  8  write data; 0 when not writing.
- mem_din  input  8  read data, valid combinationally in the same cycle as mem_rd.
- stack_ovf  output  1  sticky overflow flag.
- stack_unf  output  1  sticky underflow flag.
- dbg_is_brk  input  1  CPU halted by the debugger.
- dbg_sp_wr  input  1  debug SP write strobe.
- dbg_data_in  input  8  debug write data.

Behaviour:
- Reset (async), all outputs:
  - sp = STACK_INIT; return_addr = ret_flags = 0; all strobes, bus_req and stack_op_end = 0; ovf = unf = 0; FSM in IDLE.
  - Reset in the middle of an operation aborts it; a partially written stack is not restored.
- Occupancy: occ = (STACK_INIT − sp) mod 256, 8-bit wrap arithmetic.
- FSM states: IDLE, REQ, XFER0, XFER1, END, WAITLOW.
- IDLE, when stack_op_ongoing = 1: latch push_or_pop, push_pc and push_flags.
  - Push with STACK_DEPTH − occ < 2: set stack_ovf, go to END with no bus activity.
  - Pop with occ < 2: set stack_unf, go to END with no bus activity.
  - Otherwise go to REQ.
- REQ: bus_req = 1; go to XFER0 on the cycle bus_grant = 1.
- Transfers:
  - bus_req stays 1 through XFER0 and XFER1.
  - The strobe is asserted only while bus_grant = 1. The state advances only on a granted cycle; when grant is dropped the unit stalls with address/data held internally and outputs forced to 0.
  - Push XFER0: addr sp−1, dout push_pc, mem_wr.
  - Push XFER1: addr sp−2, dout push_flags, mem_wr; sp <= sp−2 at the end of XFER1.
  - Pop XFER0: addr sp, mem_rd; ret_flags <= mem_din.
  - Pop XFER1: addr sp+1, mem_rd; return_addr <= mem_din; sp <= sp+2 at the end of XFER1.
- END: stack_op_end = 1 for exactly one cycle; bus_req = 0. Go to WAITLOW.
- WAITLOW: return to IDLE once stack_op_ongoing = 0. This prevents re-triggering on a held request.
- Latency with grant always high: request accepted at edge 0; end pulse visible in cycle 4 (REQ, XFER0, XFER1, END). Error path: pulse in cycle 1.
- Return outputs: return_addr and ret_flags change only on a successful pop and are stable when stack_op_end is high.
- Debug write: when dbg_is_brk && dbg_sp_wr in IDLE, sp <= dbg_data_in and stack_ovf/stack_unf are cleared. Ignored in any other state.
- push_or_pop, push_pc and push_flags changes after acceptance have no effect.

Test Plan:
- Push after reset, grant tied 1, push_pc=8'h3A, push_flags=8'h05 → mem writes 8'hFF=3A, then 8'hFE=05 on consecutive cycles; sp=8'hFE; stack_op_end pulses 1 cycle in cycle 4.
- Pop immediately after that push, mem model returning stored bytes → reads at FE then FF; ret_flags=05, return_addr=3A; sp=00; both stable in the end cycle.
- Grant withheld for 3 cycles in REQ and dropped for 2 cycles between XFER0 and XFER1 → bus_req held high throughout; no strobes while ungranted; final memory contents and sp identical to the uninterrupted case.
- 16 pushes, then a 17th with STACK_DEPTH=32 → 17th performs no memory write, stack_ovf=1, sp=8'hE0 unchanged, end pulse in cycle 1. Pop on an empty stack → stack_unf=1, return_addr unchanged.
- stack_op_ongoing held high for 5 cycles after the end pulse → exactly one operation and one end pulse. Debug write dbg_data_in=8'h80 while halted → sp=80, sticky flags cleared.
- rst asserted during XFER0 of a push → all outputs 0 immediately; sp=00. A subsequent push executes normally.
